acu_sequencer: RTL and testbench
================================

ACU_SEQUENCER -- requirements
Module: acu_sequencer

Interface
REQ-001 SHALL have parameter SIZE, default 8: accumulator/data/address width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum cycles mem_req stays high waiting for mem_ack.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port instr_valid, input, 1: an instruction is offered.
REQ-006 SHALL have port instr_ready, output, 1: the sequencer accepts an instruction this cycle.
REQ-007 SHALL have port instr_op, input, 4: opcode.
REQ-008 SHALL have port instr_arg, input, SIZE: immediate value or memory address.
REQ-009 SHALL have port acc_val, input, SIZE: current accumulator output.
REQ-010 SHALL have port acu_ce, output, 1: accumulator write enable.
REQ-011 SHALL have port acu_din, output, SIZE: value to be written to the accumulator.
REQ-012 SHALL have port mem_req, output, 1: memory access request.
REQ-013 SHALL have port mem_we, output, 1: 1 = write, 0 = read; valid while mem_req is high.
REQ-014 SHALL have port mem_addr, output, SIZE: memory address.
REQ-015 SHALL have port mem_wdata, output, SIZE: memory write data.
REQ-016 SHALL have port mem_rdata, input, SIZE: memory read data; valid in the mem_ack cycle.
REQ-017 SHALL have port mem_ack, input, 1: the memory access completes this cycle.
REQ-018 SHALL have port done, output, 1: one-cycle pulse when an instruction retires.
REQ-019 SHALL have port err, output, 1: one-cycle pulse, coincident with done, on an illegal opcode or a timeout.

Function
REQ-020 SHALL decode opcodes as: 0 NOP, 1 LDI, 2 LD, 3 ST, 4 ADD, 5 SUB, 6 AND, 7 OR; opcodes 8-15 are illegal.
REQ-021 SHALL implement the states IDLE, MEM_RD, MEM_WR and WB.
REQ-022 SHALL drive instr_ready high only in IDLE; an instruction is accepted on a cycle with instr_valid and instr_ready both high, and op/arg are registered on acceptance.
REQ-023 SHALL transition from IDLE on acceptance as follows: LD/ADD/SUB/AND/OR -> MEM_RD; ST -> MEM_WR; NOP/LDI/illegal -> WB.
REQ-024 SHALL, in MEM_RD, hold mem_req=1, mem_we=0 and mem_addr=arg, and on mem_ack capture mem_rdata and go to WB.
REQ-025 SHALL, in MEM_WR, hold mem_req=1, mem_we=1, mem_addr=arg and mem_wdata=acc_val sampled at acceptance (stable throughout), and on mem_ack go to WB.
REQ-026 SHALL, in WB, pulse done for exactly one cycle, then return to IDLE.
REQ-027 SHALL, in WB, assert acu_ce only for LDI, LD, ADD, SUB, AND and OR, and only when no timeout occurred.
REQ-028 SHALL drive acu_din in WB as: LDI arg; LD rdata; ADD acc+rdata; SUB acc-rdata; AND acc&rdata; OR acc|rdata; all results mod 2^SIZE, carry/borrow discarded, acc = acc_val sampled at acceptance.
REQ-029 SHALL drive acu_din to 0 whenever acu_ce is low.
REQ-030 SHALL count the cycles mem_req is high; if mem_ack has not arrived after TIMEOUT cycles, drop mem_req, go to WB and assert err with acu_ce=0.
REQ-031 SHALL treat mem_ack arriving in the same cycle as the timeout expiry as a normal completion, with no err.
REQ-032 SHALL ignore mem_ack outside MEM_RD and MEM_WR.
REQ-033 SHALL, for an illegal opcode, produce no memory access and no accumulator write, and assert err in WB.
REQ-034 SHALL give the following latencies, for acceptance in cycle N: NOP/LDI/illegal -> WB (done) in N+1 and ready again in N+2; memory ops -> mem_req from N+1, and for ack in cycle M, WB in M+1 and ready in M+2.
REQ-035 SHALL keep mem_req, done and acu_ce low in every state except where specified above.

Reset
REQ-036 SHALL, while rstn is low, asynchronously force the state to IDLE and drive acu_ce, acu_din, mem_req, mem_we, mem_addr, mem_wdata, done, err and the timeout counter to 0, and instr_ready to 0.
REQ-037 SHALL drive instr_ready=1 in the first cycle after rstn deasserts.
REQ-038 SHALL, if reset asserts mid-instruction, drop mem_req immediately and perform no accumulator write and no done for that instruction.

Verification
REQ-039 SHALL be verified with: LDI arg=0x5A accepted in cycle N -> acu_ce=1 and acu_din=0x5A in N+1, done=1, err=0.
REQ-040 SHALL be verified with: acc_val=0xF0, ADD arg=0x10, rdata=0x20 with ack after 3 cycles -> mem_addr=0x10, then acu_din=0x10 (wrap), acu_ce=1 for exactly 1 cycle.
REQ-041 SHALL be verified with: acc_val=0x33, ST arg=0x80 -> mem_we=1, mem_wdata=0x33, mem_addr=0x80 until ack, then done=1 with acu_ce=0.
REQ-042 SHALL be verified with: LD and no mem_ack ever -> mem_req high for exactly 15 cycles, then done=1, err=1, acu_ce=0.
REQ-043 SHALL be verified with: opcode 0xB -> no mem_req, done=1 and err=1 in N+1, instr_ready=1 in N+2.
REQ-044 SHALL be verified with: rstn pulsed low during MEM_RD -> mem_req=0 at once, no done, instr_ready=1 after release.

Source files
------------

// File: rtl/acu_sequencer.sv
`timescale 1ns/1ps
// Instruction sequencer for an accumulator unit: accepts one instruction at a time,
// performs at most one memory access, then retires it with an accumulator write-back.
//
// state  | meaning
// IDLE   | instr_ready high, waiting for an instruction
// MEM_RD | read request outstanding at arg, timeout counter running
// MEM_WR | write request of sampled acc to arg, timeout counter running
// WB     | one-cycle retire: done, optional acu_ce, err on illegal/timeout
module acu_sequencer #(
   parameter int SIZE    = 8,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [3:0]      instr_op,
   input  logic [SIZE-1:0] instr_arg,
   input  logic [SIZE-1:0] acc_val,
   output logic            acu_ce,
   output logic [SIZE-1:0] acu_din,
   output logic            mem_req,
   output logic            mem_we,
   output logic [SIZE-1:0] mem_addr,
   output logic [SIZE-1:0] mem_wdata,
   input  logic [SIZE-1:0] mem_rdata,
   input  logic            mem_ack,
   output logic            done,
   output logic            err
);

   localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0]   TMO_LOAD = CW'(TIMEOUT - 1);

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LDI = 4'd1;
   localparam logic [3:0] OP_LD  = 4'd2;
   localparam logic [3:0] OP_ST  = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4;
   localparam logic [3:0] OP_SUB = 4'd5;
   localparam logic [3:0] OP_AND = 4'd6;
   localparam logic [3:0] OP_OR  = 4'd7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MEM_RD = 2'd1,
      MEM_WR = 2'd2,
      WB     = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      op_q;
   logic [SIZE-1:0] arg_q;
   logic [SIZE-1:0] acc_q;
   logic [SIZE-1:0] rdata_q;
   logic            tmo_q;
   logic [CW-1:0]   cnt_q;
   logic            accept;
   logic            writes_acc;
   logic            illegal;
   logic [SIZE-1:0] result;

   assign accept  = instr_valid & instr_ready;
   assign illegal = op_q[3];

   always_comb begin
      writes_acc = 1'b0;
      result     = '0;
      case (op_q)
         OP_LDI: begin writes_acc = 1'b1; result = arg_q;             end
         OP_LD:  begin writes_acc = 1'b1; result = rdata_q;           end
         OP_ADD: begin writes_acc = 1'b1; result = acc_q + rdata_q;   end
         OP_SUB: begin writes_acc = 1'b1; result = acc_q - rdata_q;   end
         OP_AND: begin writes_acc = 1'b1; result = acc_q & rdata_q;   end
         OP_OR:  begin writes_acc = 1'b1; result = acc_q | rdata_q;   end
         default: begin writes_acc = 1'b0; result = '0;               end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // All outputs decode from state so that reset (state forced to IDLE) silences them at once.
   always_comb begin
      state_d     = state_q;
      instr_ready = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      done        = 1'b0;
      err         = 1'b0;
      acu_ce      = 1'b0;
      acu_din     = '0;
      case (state_q)
         IDLE: begin
            instr_ready = rstn;
            if (accept) begin
               case (instr_op)
                  OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = MEM_RD;
                  OP_ST:                                state_d = MEM_WR;
                  default:                              state_d = WB;
               endcase
            end
         end
         MEM_RD: begin
            mem_req  = 1'b1;
            mem_addr = arg_q;
            if (mem_ack || (cnt_q == '0)) begin
               state_d = WB;
            end
         end
         MEM_WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = arg_q;
            mem_wdata = acc_q;
            if (mem_ack || (cnt_q == '0)) begin
               state_d = WB;
            end
         end
         WB: begin
            done    = 1'b1;
            err     = illegal | tmo_q;
            acu_ce  = writes_acc & ~tmo_q;
            acu_din = (writes_acc & ~tmo_q) ? result : '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Timeout is a down-counter; an ack in the terminal-count cycle wins over expiry.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_q    <= OP_NOP;
         arg_q   <= '0;
         acc_q   <= '0;
         rdata_q <= '0;
         tmo_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (accept) begin
         op_q    <= instr_op;
         arg_q   <= instr_arg;
         acc_q   <= acc_val;
         tmo_q   <= 1'b0;
         cnt_q   <= TMO_LOAD;
      end else if (mem_req) begin
         if (mem_ack) begin
            rdata_q <= mem_rdata;
         end else if (cnt_q == '0) begin
            tmo_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_acu_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for acu_sequencer: expected retire records are queued at issue
// and popped when done pulses; memory handshakes are checked inline by the driver.
module tb_acu_sequencer;

   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       rstn;
   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] instr_op;
   logic [7:0] instr_arg;
   logic [7:0] acc_val;
   logic       acu_ce;
   logic [7:0] acu_din;
   logic       mem_req;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       mem_ack;
   logic       done;
   logic       err;

   typedef struct packed {
      logic       err;
      logic       ce;
      logic [7:0] din;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   acu_sequencer #(.SIZE(8), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_op    (instr_op),
      .instr_arg   (instr_arg),
      .acc_val     (acc_val),
      .acu_ce      (acu_ce),
      .acu_din     (acu_din),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .done        (done),
      .err         (err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [7:0] arg,
                                  input logic [7:0] acc, input logic [7:0] rdata, input bit tmo);
      exp_t e;
      e.err = op[3] | tmo;
      e.ce  = 1'b0;
      e.din = 8'h00;
      if (!op[3] && !tmo) begin
         case (op)
            4'd1: begin e.ce = 1'b1; e.din = arg;          end
            4'd2: begin e.ce = 1'b1; e.din = rdata;        end
            4'd4: begin e.ce = 1'b1; e.din = acc + rdata;  end
            4'd5: begin e.ce = 1'b1; e.din = acc - rdata;  end
            4'd6: begin e.ce = 1'b1; e.din = acc & rdata;  end
            4'd7: begin e.ce = 1'b1; e.din = acc | rdata;  end
            default: begin e.ce = 1'b0; e.din = 8'h00;     end
         endcase
      end
      return e;
   endfunction

   // Retire monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'(0));
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("wb_err", 32'(err), 32'(e.err));
               chk("wb_acu_ce", 32'(acu_ce), 32'(e.ce));
               chk("wb_acu_din", 32'(acu_din), 32'(e.din));
            end
         end else if (acu_ce !== 1'b0) begin
            chk("acu_ce_outside_wb", 32'(acu_ce), 32'(0));
         end
      end
   end

   // ack_dly: number of mem cycles before ack (0 = ack in first cycle); negative = never.
   task automatic issue(input logic [3:0] op, input logic [7:0] arg, input logic [7:0] acc,
                        input logic [7:0] rdata, input int ack_dly);
      int w;
      int cyc;
      int exp_cyc;
      bit memop;
      bit tmo;
      w = 0;
      while (instr_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (instr_ready !== 1'b1) chk("ready_wait", 32'(instr_ready), 32'(1));
      memop = (op >= 4'd2) && (op <= 4'd7);
      tmo   = memop && ((ack_dly < 0) || (ack_dly >= TIMEOUT));
      sb_q.push_back(model(op, arg, acc, rdata, tmo));
      instr_valid = 1'b1;
      instr_op    = op;
      instr_arg   = arg;
      acc_val     = acc;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      instr_op    = 4'($urandom);
      instr_arg   = 8'($urandom);
      acc_val     = 8'($urandom);
      if (memop) begin
         chk("mem_req_start", 32'(mem_req), 32'(1));
         cyc = 0;
         while (mem_req === 1'b1 && cyc < 40) begin
            chk("mem_addr", 32'(mem_addr), 32'(arg));
            chk("mem_we", 32'(mem_we), 32'(op == 4'd3));
            if (op == 4'd3) chk("mem_wdata", 32'(mem_wdata), 32'(acc));
            if (cyc == ack_dly) begin
               mem_ack   = 1'b1;
               mem_rdata = rdata;
            end
            cyc++;
            @(posedge clk);
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
         end
         exp_cyc = tmo ? TIMEOUT : ack_dly + 1;
         chk("mem_cycles", 32'(cyc), 32'(exp_cyc));
      end else begin
         chk("no_mem_req", 32'(mem_req), 32'(0));
      end
      chk("done_pulse", 32'(done), 32'(1));
      @(posedge clk);
      @(negedge clk);
      chk("ready_after", 32'(instr_ready), 32'(1));
      chk("done_once", 32'(done), 32'(0));
   endtask

   initial begin
      rstn        = 1'b0;
      instr_valid = 1'b0;
      instr_op    = 4'd0;
      instr_arg   = 8'h00;
      acc_val     = 8'h00;
      mem_rdata   = 8'h00;
      mem_ack     = 1'b0;
      #1;
      chk("rst_ready", 32'(instr_ready), 32'(0));
      chk("rst_mem_req", 32'(mem_req), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_acu_ce", 32'(acu_ce), 32'(0));
      chk("rst_acu_din", 32'(acu_din), 32'(0));
      chk("rst_mem_addr", 32'(mem_addr), 32'(0));
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("ready_after_rst", 32'(instr_ready), 32'(1));
      @(negedge clk);

      issue(4'd1, 8'h5A, 8'h00, 8'h00, 0);        // LDI
      issue(4'd4, 8'h10, 8'hF0, 8'h20, 3);        // ADD with wrap
      issue(4'd3, 8'h80, 8'h33, 8'h00, 2);        // ST
      issue(4'd2, 8'h44, 8'h00, 8'hA5, -1);       // LD timeout
      issue(4'hB, 8'h12, 8'h34, 8'h00, 0);        // illegal
      issue(4'd0, 8'h77, 8'h11, 8'h00, 0);        // NOP
      issue(4'd2, 8'h09, 8'h00, 8'hC3, TIMEOUT-1);// ack on expiry cycle
      issue(4'd5, 8'h01, 8'h10, 8'h20, 0);        // SUB with borrow
      issue(4'd6, 8'h02, 8'hF0, 8'h3C, 1);
      issue(4'd7, 8'h03, 8'h81, 8'h18, 4);
      issue(4'd3, 8'hFF, 8'hC7, 8'h00, -1);       // ST timeout

      // ack while idle must be ignored
      mem_ack = 1'b1;
      repeat (2) @(negedge clk);
      mem_ack = 1'b0;
      chk("idle_ack_done", 32'(done), 32'(0));
      chk("idle_ack_ready", 32'(instr_ready), 32'(1));

      for (int i = 0; i < 20; i++) begin
         issue(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 5)));
      end

      // reset in the middle of a read
      instr_valid = 1'b1;
      instr_op    = 4'd2;
      instr_arg   = 8'h66;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_mem_req_before", 32'(mem_req), 32'(1));
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_rst_mem_req", 32'(mem_req), 32'(0));
      chk("mid_rst_ready", 32'(instr_ready), 32'(0));
      chk("mid_rst_done", 32'(done), 32'(0));
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("mid_release_ready", 32'(instr_ready), 32'(1));
      repeat (2) @(negedge clk);
      chk("mid_no_done", 32'(done), 32'(0));
      chk("mid_no_mem_req", 32'(mem_req), 32'(0));

      issue(4'd1, 8'hC8, 8'h00, 8'h00, 0);
      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
